// File: rtl/frame_draw_scheduler_pkg.sv
// Shared constants and types for the frame draw scheduler: screen and object
// geometry, coordinate width, sweep states and the latched object snapshot.
package draw_pkg;

    localparam int COORD_W   = 11;
    localparam int SUM_W     = COORD_W + 1;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int PIPE_W    = 40;
    localparam int GAP_H     = 100;
    localparam int BIRD_SIZE = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OBJ_RECT = 1'b0,
        OBJ_PIPE = 1'b1
    } obj_kind_e;

    typedef struct packed {
        coord_t pipe1X;
        coord_t pipe1Y;
        coord_t pipe2X;
        coord_t pipe2Y;
        coord_t birdX;
        coord_t birdY;
    } scene_t;

endpackage

// File: rtl/frame_draw_scheduler_if.sv
// Framebuffer write port driven by the scheduler: address, colour and strobe.
interface frame_draw_scheduler_if;
    import draw_pkg::*;

    coord_t x;
    coord_t y;
    logic   color;
    logic   pixel_write;

    modport master (output x, y, color, pixel_write);
    modport slave  (input  x, y, color, pixel_write);

endinterface

// File: rtl/frame_draw_scheduler_object_hit.sv
// Combinational hit test of one scan position against a bird square or a pipe
// (full-height column with a vertical opening of GAP rows ending at oy_i).
module object_hit
    import draw_pkg::*;
#(
    parameter int SIZE_X = 10,
    parameter int SIZE_Y = 10,
    parameter int GAP    = 0
) (
    input  coord_t    cx_i,
    input  coord_t    cy_i,
    input  coord_t    ox_i,
    input  coord_t    oy_i,
    input  obj_kind_e kind_i,
    output logic      hit_o
);

    logic [SUM_W-1:0] xEnd;
    logic [SUM_W-1:0] yEnd;
    logic [SUM_W-1:0] gapDiff;
    logic [SUM_W-1:0] gapTop;
    logic             inX;
    logic             inRectY;
    logic             inPipeY;

    // 12-bit sums keep objects near the right/bottom edge from wrapping to 0.
    assign xEnd    = {1'b0, ox_i} + SUM_W'(SIZE_X);
    assign yEnd    = {1'b0, oy_i} + SUM_W'(SIZE_Y);
    assign gapDiff = {1'b0, oy_i} - SUM_W'(GAP);
    assign gapTop  = gapDiff[SUM_W-1] ? '0 : gapDiff;

    assign inX     = (cx_i >= ox_i) && ({1'b0, cx_i} < xEnd);
    assign inRectY = (cy_i >= oy_i) && ({1'b0, cy_i} < yEnd);
    assign inPipeY = ({1'b0, cy_i} < gapTop) || (cy_i >= oy_i);

    assign hit_o   = inX && ((kind_i == OBJ_PIPE) ? inPipeY : inRectY);

endmodule

// File: rtl/frame_draw_scheduler.sv
// One raster sweep per game tick over the whole screen, writing background or
// object colour at every pixel from a snapshot of the object coordinates.
module frame_draw_scheduler #(
    parameter int SCREEN_W  = draw_pkg::SCREEN_W,
    parameter int SCREEN_H  = draw_pkg::SCREEN_H,
    parameter int PIPE_W    = draw_pkg::PIPE_W,
    parameter int GAP_H     = draw_pkg::GAP_H,
    parameter int BIRD_SIZE = draw_pkg::BIRD_SIZE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_tick,
    input  logic                  force_clear,
    input  draw_pkg::coord_t      pipe1_x,
    input  draw_pkg::coord_t      pipe1_y,
    input  draw_pkg::coord_t      pipe2_x,
    input  draw_pkg::coord_t      pipe2_y,
    input  draw_pkg::coord_t      bird_x,
    input  draw_pkg::coord_t      bird_y,
    frame_draw_scheduler_if.master fb,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);
    import draw_pkg::*;

    localparam coord_t LAST_X = coord_t'(SCREEN_W - 1);
    localparam coord_t LAST_Y = coord_t'(SCREEN_H - 1);

    state_e state_q, state_d;
    coord_t cx_q, cx_d;
    coord_t cy_q, cy_d;
    scene_t scene_q, scene_d;
    logic   forceClr_q, forceClr_d;
    logic   pending_q, pending_d;
    logic   overrun_q, overrun_d;
    coord_t x_q, y_q;
    logic   color_q, write_q, done_q;
    logic   launch;
    logic   hitPipe1, hitPipe2, hitBird;

    object_hit #(.SIZE_X(PIPE_W), .SIZE_Y(0), .GAP(GAP_H)) uPipe1 (
        .cx_i(cx_q), .cy_i(cy_q), .ox_i(scene_q.pipe1X), .oy_i(scene_q.pipe1Y),
        .kind_i(OBJ_PIPE), .hit_o(hitPipe1)
    );

    object_hit #(.SIZE_X(PIPE_W), .SIZE_Y(0), .GAP(GAP_H)) uPipe2 (
        .cx_i(cx_q), .cy_i(cy_q), .ox_i(scene_q.pipe2X), .oy_i(scene_q.pipe2Y),
        .kind_i(OBJ_PIPE), .hit_o(hitPipe2)
    );

    object_hit #(.SIZE_X(BIRD_SIZE), .SIZE_Y(BIRD_SIZE), .GAP(0)) uBird (
        .cx_i(cx_q), .cy_i(cy_q), .ox_i(scene_q.birdX), .oy_i(scene_q.birdY),
        .kind_i(OBJ_RECT), .hit_o(hitBird)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            scene_q    <= '0;
            forceClr_q <= 1'b0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            color_q    <= 1'b0;
            write_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            scene_q    <= scene_d;
            forceClr_q <= forceClr_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            x_q        <= cx_q;
            y_q        <= cy_q;
            color_q    <= (state_q == SCAN) && !forceClr_q && (hitPipe1 || hitPipe2 || hitBird);
            write_q    <= (state_q == SCAN);
            done_q     <= (state_q == DONE);
        end
    end

    // A tick arriving mid-sweep is held one deep; DONE relaunches straight into SCAN.
    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        scene_d    = scene_q;
        forceClr_d = forceClr_q;
        pending_d  = pending_q;
        overrun_d  = 1'b0;
        launch     = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_tick || pending_q) begin
                    launch    = 1'b1;
                    pending_d = 1'b0;
                end
            end
            SCAN: begin
                if (frame_tick) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (cx_q == LAST_X) begin
                    cx_d = '0;
                    if (cy_q == LAST_Y) begin
                        cy_d    = '0;
                        state_d = DONE;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (pending_q) begin
                    launch    = 1'b1;
                    pending_d = frame_tick;
                end else if (frame_tick) begin
                    pending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d        = SCAN;
            cx_d           = '0;
            cy_d           = '0;
            forceClr_d     = force_clear;
            scene_d.pipe1X = pipe1_x;
            scene_d.pipe1Y = pipe1_y;
            scene_d.pipe2X = pipe2_x;
            scene_d.pipe2Y = pipe2_y;
            scene_d.birdX  = bird_x;
            scene_d.birdY  = bird_y;
        end
    end

    assign fb.x           = x_q;
    assign fb.y           = y_q;
    assign fb.color       = color_q;
    assign fb.pixel_write = write_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = done_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Bench for frame_draw_scheduler on a reduced 64x48 screen: a monitor captures
// every write, and each test task compares captured frames with a pixel model.
module tb_frame_draw_scheduler;
    import draw_pkg::*;

    localparam int W   = 64;
    localparam int H   = 48;
    localparam int PW  = 8;
    localparam int GAP = 10;
    localparam int BS  = 4;
    localparam int N   = W * H;

    typedef struct {
        int p1x, p1y, p2x, p2y, bx, by;
        bit clr;
    } tbScene_t;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    logic   frame_tick = 1'b0;
    logic   force_clear = 1'b0;
    coord_t pipe1_x = '0, pipe1_y = '0, pipe2_x = '0, pipe2_y = '0, bird_x = '0, bird_y = '0;
    logic   busy, frame_done, overrun;

    frame_draw_scheduler_if fb();

    frame_draw_scheduler #(
        .SCREEN_W(W), .SCREEN_H(H), .PIPE_W(PW), .GAP_H(GAP), .BIRD_SIZE(BS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .force_clear(force_clear),
        .pipe1_x(pipe1_x), .pipe1_y(pipe1_y), .pipe2_x(pipe2_x), .pipe2_y(pipe2_y),
        .bird_x(bird_x), .bird_y(bird_y), .fb(fb),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    logic fbMem [2][N];
    int   frameIdx = 0, wrCount = 0, orderErr = 0, nextIdx = 0, monIdx = 0;
    int   firstWriteCyc = -1, lastWriteCyc = -1, doneCyc = -1, doneCount = 0, overrunCount = 0;

    // Capture writes into the buffer of the frame in flight and track raster order.
    always @(negedge clk) begin
        if (!reset_n) begin
            nextIdx = 0;
        end else begin
            if (fb.pixel_write) begin
                monIdx = int'(fb.y) * W + int'(fb.x);
                if (monIdx != nextIdx) orderErr++;
                if (nextIdx == 0) firstWriteCyc = cyc;
                if (monIdx < N) fbMem[frameIdx % 2][monIdx] = fb.color;
                nextIdx = (nextIdx + 1) % N;
                wrCount++;
                lastWriteCyc = cyc;
            end
            if (frame_done) begin
                doneCount++;
                doneCyc = cyc;
                frameIdx++;
            end
            if (overrun) overrunCount++;
        end
    end

    function automatic bit inPipe(input int cx, input int cy, input int px, input int py);
        int top;
        top = (py < GAP) ? 0 : py - GAP;
        return (cx >= px) && (cx < px + PW) && ((cy < top) || (cy >= py));
    endfunction

    function automatic bit modelPixel(input tbScene_t s, input int cx, input int cy);
        bit bird;
        bird = (cx >= s.bx) && (cx < s.bx + BS) && (cy >= s.by) && (cy < s.by + BS);
        if (s.clr) return 1'b0;
        return bird || inPipe(cx, cy, s.p1x, s.p1y) || inPipe(cx, cy, s.p2x, s.p2y);
    endfunction

    function automatic int countMismatch(input tbScene_t s, input int b, output int fx, output int fy);
        int n;
        n  = 0;
        fx = -1;
        fy = -1;
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                if (fbMem[b][yy * W + xx] !== modelPixel(s, xx, yy)) begin
                    if (n == 0) begin
                        fx = xx;
                        fy = yy;
                    end
                    n++;
                end
            end
        end
        return n;
    endfunction

    function automatic tbScene_t randScene();
        tbScene_t s;
        s.p1x = $urandom_range(0, W + 4);
        s.p1y = $urandom_range(0, H + 5);
        s.p2x = $urandom_range(0, W + 4);
        s.p2y = $urandom_range(0, H + 5);
        s.bx  = $urandom_range(0, W - 1);
        s.by  = $urandom_range(0, H - 1);
        s.clr = 1'b0;
        return s;
    endfunction

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input tbScene_t s);
        pipe1_x     = coord_t'(s.p1x);
        pipe1_y     = coord_t'(s.p1y);
        pipe2_x     = coord_t'(s.p2x);
        pipe2_y     = coord_t'(s.p2y);
        bird_x      = coord_t'(s.bx);
        bird_y      = coord_t'(s.by);
        force_clear = s.clr;
    endtask

    task automatic pulseTick();
        frame_tick = 1'b1;
        nextCycle();
        frame_tick = 1'b0;
    endtask

    task automatic waitDone(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < N + 200; i++) begin
            if (doneCount >= target) begin
                ok = 1'b1;
                break;
            end
            nextCycle();
        end
    endtask

    task automatic runFrame(input tbScene_t s, output int b, output bit ok);
        int d0;
        b  = frameIdx % 2;
        d0 = doneCount;
        applyStimulus(s);
        pulseTick();
        waitDone(d0 + 1, ok);
    endtask

    task automatic test_reset();
        tbScene_t s;
        bit found;
        int w0;
        s = '{20, 30, 60, 25, 5, 24, 1'b0};
        reset_n = 1'b0;
        repeat (3) nextCycle();
        total++;
        if ({fb.pixel_write, fb.color, busy, frame_done, overrun} !== 5'b0 || fb.x !== '0 || fb.y !== '0) begin
            bad++;
            $display("[TB] FAIL reset_state: got wr=%b col=%b busy=%b done=%b ovr=%b x=%0d y=%0d, expected all 0",
                     fb.pixel_write, fb.color, busy, frame_done, overrun, fb.x, fb.y);
        end
        reset_n = 1'b1;
        nextCycle();

        applyStimulus(s);
        pulseTick();
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (fb.pixel_write === 1'b1 && fb.x === coord_t'(10) && fb.y === coord_t'(5)) begin
                found = 1'b1;
                break;
            end
            nextCycle();
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL reach_10_5: got no write at (10,5), expected one within %0d cycles", N);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (fb.pixel_write !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_wr_busy: got wr=%b busy=%b, expected 0 0", fb.pixel_write, busy);
        end
        total++;
        if (fb.x !== '0 || fb.y !== '0 || fb.color !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_xyc: got x=%0d y=%0d col=%b, expected 0 0 0", fb.x, fb.y, fb.color);
        end
        w0 = wrCount;
        repeat (3) nextCycle();
        reset_n = 1'b1;
        repeat (20) nextCycle();
        total++;
        if (wrCount !== w0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle: got %0d writes busy=%b after release, expected 0 writes busy=0",
                     wrCount - w0, busy);
        end
    endtask

    task automatic test_directed_frame();
        tbScene_t s;
        int b, w0, o0, mm, fx, fy;
        bit ok;
        int pts [9][3] = '{'{20, 19, 1}, '{20, 20, 0}, '{27, 29, 0}, '{27, 30, 1}, '{28, 30, 0},
                           '{6, 25, 1}, '{9, 25, 0}, '{63, 10, 1}, '{0, 10, 0}};
        s  = '{20, 30, 60, 25, 5, 24, 1'b0};
        w0 = wrCount;
        o0 = orderErr;
        runFrame(s, b, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL directed_timeout: got no frame_done, expected one within %0d cycles", N + 200);
        end
        total++;
        if (wrCount - w0 !== N || orderErr - o0 !== 0) begin
            bad++;
            $display("[TB] FAIL directed_writes: got %0d writes %0d out of order, expected %0d writes 0 out of order",
                     wrCount - w0, orderErr - o0, N);
        end
        total++;
        if (lastWriteCyc - firstWriteCyc + 1 !== N) begin
            bad++;
            $display("[TB] FAIL directed_consecutive: got span %0d cycles, expected %0d", lastWriteCyc - firstWriteCyc + 1, N);
        end
        total++;
        if (doneCyc !== lastWriteCyc + 1) begin
            bad++;
            $display("[TB] FAIL directed_done_latency: got done at %0d, expected %0d", doneCyc, lastWriteCyc + 1);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (fbMem[b][pts[i][1] * W + pts[i][0]] !== 1'(pts[i][2])) begin
                bad++;
                $display("[TB] FAIL directed_pixel(%0d,%0d): got %b, expected %0d",
                         pts[i][0], pts[i][1], fbMem[b][pts[i][1] * W + pts[i][0]], pts[i][2]);
            end
        end
        mm = countMismatch(s, b, fx, fy);
        total++;
        if (mm !== 0) begin
            bad++;
            $display("[TB] FAIL directed_model: got %0d wrong pixels (first at %0d,%0d), expected 0", mm, fx, fy);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL directed_busy_after: got %b, expected 0", busy);
        end
    endtask

    task automatic test_random_frames();
        tbScene_t s;
        int b, w0, mm, fx, fy;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            s  = randScene();
            w0 = wrCount;
            runFrame(s, b, ok);
            mm = countMismatch(s, b, fx, fy);
            total++;
            if (!ok || wrCount - w0 !== N || mm !== 0) begin
                bad++;
                $display("[TB] FAIL random_frame%0d: got done=%b writes=%0d wrong=%0d (first %0d,%0d), expected 1 %0d 0",
                         k, ok, wrCount - w0, mm, fx, fy, N);
            end
        end
    endtask

    task automatic test_force_clear();
        tbScene_t s;
        int b, w0, ones;
        bit ok;
        s    = '{20, 30, 60, 25, 5, 24, 1'b1};
        w0   = wrCount;
        runFrame(s, b, ok);
        ones = 0;
        for (int i = 0; i < N; i++) if (fbMem[b][i] !== 1'b0) ones++;
        total++;
        if (!ok || wrCount - w0 !== N || ones !== 0) begin
            bad++;
            $display("[TB] FAIL force_clear: got done=%b writes=%0d nonzero=%0d, expected 1 %0d 0",
                     ok, wrCount - w0, ones, N);
        end
    endtask

    task automatic test_clip();
        tbScene_t s;
        int b, mm, fx, fy, topOnes;
        bit ok;
        int pts [5][3] = '{'{60, 0, 1}, '{63, 0, 1}, '{59, 0, 0}, '{0, 0, 0}, '{3, 0, 0}};
        s = '{20, 5, 60, 30, 40, 40, 1'b0};
        runFrame(s, b, ok);
        topOnes = 0;
        for (int r = 0; r < 5; r++) if (fbMem[b][r * W + 20] !== 1'b0) topOnes++;
        total++;
        if (!ok || topOnes !== 0) begin
            bad++;
            $display("[TB] FAIL clip_gap_top: got done=%b nonzero rows 0-4 of col 20=%0d, expected 1 0", ok, topOnes);
        end
        total++;
        if (fbMem[b][5 * W + 20] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL clip_row5: got %b, expected 1", fbMem[b][5 * W + 20]);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (fbMem[b][pts[i][1] * W + pts[i][0]] !== 1'(pts[i][2])) begin
                bad++;
                $display("[TB] FAIL clip_pixel(%0d,%0d): got %b, expected %0d",
                         pts[i][0], pts[i][1], fbMem[b][pts[i][1] * W + pts[i][0]], pts[i][2]);
            end
        end
        mm = countMismatch(s, b, fx, fy);
        total++;
        if (mm !== 0) begin
            bad++;
            $display("[TB] FAIL clip_model: got %0d wrong pixels (first at %0d,%0d), expected 0", mm, fx, fy);
        end
    endtask

    task automatic test_back_to_back();
        tbScene_t sa, sb;
        int b, d0, ov0, w0, busyLow, last1, done1, wrMid, mm1, mm2, fx, fy;
        bit got1, got2, relaunchBusy;
        sa  = randScene();
        sb  = randScene();
        b   = frameIdx % 2;
        d0  = doneCount;
        ov0 = overrunCount;
        w0  = wrCount;
        busyLow = 0;
        got1 = 1'b0;
        got2 = 1'b0;
        relaunchBusy = 1'b0;
        last1 = -1;
        done1 = -1;
        wrMid = -1;
        applyStimulus(sa);
        pulseTick();
        for (int i = 1; i < 3 * N; i++) begin
            frame_tick = (i == 500 || i == 1000);
            if (i == 100) applyStimulus(sb);
            nextCycle();
            if (!got1 && doneCount >= d0 + 1) begin
                got1  = 1'b1;
                last1 = lastWriteCyc;
                done1 = doneCyc;
                wrMid = wrCount - w0;
                relaunchBusy = busy;
            end
            if (doneCount >= d0 + 2) begin
                got2 = 1'b1;
                break;
            end
            if (busy !== 1'b1) busyLow++;
        end
        frame_tick = 1'b0;
        total++;
        if (!got1 || !got2) begin
            bad++;
            $display("[TB] FAIL b2b_frames: got first=%b second=%b, expected both frames done", got1, got2);
        end
        total++;
        if (overrunCount - ov0 !== 1) begin
            bad++;
            $display("[TB] FAIL b2b_overrun: got %0d pulses, expected 1", overrunCount - ov0);
        end
        total++;
        if (busyLow !== 0 || relaunchBusy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_busy: got %0d low cycles relaunch busy=%b, expected 0 1", busyLow, relaunchBusy);
        end
        total++;
        if (firstWriteCyc !== done1 + 1 || done1 !== last1 + 1) begin
            bad++;
            $display("[TB] FAIL b2b_no_idle: got frame2 first write %0d done1 %0d, expected %0d %0d",
                     firstWriteCyc, done1, done1 + 1, last1 + 1);
        end
        total++;
        if (wrMid !== N || wrCount - w0 !== 2 * N) begin
            bad++;
            $display("[TB] FAIL b2b_writes: got %0d then %0d, expected %0d then %0d", wrMid, wrCount - w0, N, 2 * N);
        end
        mm1 = countMismatch(sa, b, fx, fy);
        total++;
        if (mm1 !== 0) begin
            bad++;
            $display("[TB] FAIL b2b_frame1_model: got %0d wrong pixels (first at %0d,%0d), expected 0", mm1, fx, fy);
        end
        mm2 = countMismatch(sb, 1 - b, fx, fy);
        total++;
        if (mm2 !== 0) begin
            bad++;
            $display("[TB] FAIL b2b_frame2_model: got %0d wrong pixels (first at %0d,%0d), expected 0", mm2, fx, fy);
        end
    endtask

    task automatic test_coord_change();
        tbScene_t s;
        int b, d0, mm, fx, fy;
        bit ok;
        s  = '{W + 2, 20, W + 2, 20, 30, 24, 1'b0};
        b  = frameIdx % 2;
        d0 = doneCount;
        applyStimulus(s);
        pulseTick();
        repeat (9) nextCycle();
        bird_y = coord_t'(10);
        waitDone(d0 + 1, ok);
        total++;
        if (!ok || fbMem[b][24 * W + 31] !== 1'b1 || fbMem[b][27 * W + 31] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL coord_hold_old: got done=%b (31,24)=%b (31,27)=%b, expected 1 1 1",
                     ok, fbMem[b][24 * W + 31], fbMem[b][27 * W + 31]);
        end
        total++;
        if (fbMem[b][10 * W + 31] !== 1'b0 || fbMem[b][28 * W + 31] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL coord_hold_new: got (31,10)=%b (31,28)=%b, expected 0 0",
                     fbMem[b][10 * W + 31], fbMem[b][28 * W + 31]);
        end
        mm = countMismatch(s, b, fx, fy);
        total++;
        if (mm !== 0) begin
            bad++;
            $display("[TB] FAIL coord_model: got %0d wrong pixels (first at %0d,%0d), expected 0", mm, fx, fy);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish by %0d ns, expected earlier finish", 2000000);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_directed_frame();
        test_random_frames();
        test_force_clear();
        test_clip();
        test_back_to_back();
        test_coord_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
